// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the data-memory bridge: FSM states, access
// size decode and the misalignment test.
package dmem_bridge_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3Byte      = 3'b000;
  localparam logic [2:0] F3Half      = 3'b001;
  localparam logic [2:0] F3Word      = 3'b010;
  localparam logic [2:0] F3ByteUnsgn = 3'b100;
  localparam logic [2:0] F3HalfUnsgn = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Undefined encodings (011, 110, 111) fall through to word.
  function automatic size_e f3_size(logic [2:0] f3);
    case (f3)
      F3Byte, F3ByteUnsgn: return SzByte;
      F3Half, F3HalfUnsgn: return SzHalf;
      default:             return SzWord;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SzHalf:  return off[0];
      SzWord:  return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_align.sv
// Combinational lane logic: store data replication and byte-enable generation,
// plus load byte/halfword select with sign or zero extension.
module dmem_bridge_align
  import dmem_bridge_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_zext;

  // Store steering: replicate narrow data so the enabled lane always carries it.
  always_comb begin
    st_wdata_o = st_wdata_i;
    st_be_o    = 4'b1111;
    case (f3_size(st_funct3_i))
      SzByte: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_be_o    = 4'b0001 << st_off_i;
      end
      SzHalf: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load select and extension; funct3[2] marks the unsigned variants.
  always_comb begin
    ld_zext = ld_funct3_i[2];
    ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_off_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    case (f3_size(ld_funct3_i))
      SzByte:  ld_data_o = {{24{~ld_zext & ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data_o = {{16{~ld_zext & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core load/store port to req/ack data SRAM bridge. Three-state FSM
// (IDLE -> REQ -> DONE) with registered memory-side outputs and a
// combinational core stall.
// Build option: DMEM_MISALIGN_TRAP_EN traps misaligned H/W accesses
// (no memory request, cpu_fault for the DONE cycle); undefined, low
// address bits are ignored and cpu_fault is tied low.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         data_q, data_d;
  logic                fault_q, fault_d;

  logic [31:0]         st_wdata;
  logic [3:0]          st_be;
  logic [31:0]         ld_data;

  // Upper address bits alias onto the same word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

  dmem_bridge_align u_align (
    .st_funct3_i (cpu_funct3),
    .st_off_i    (cpu_addr[1:0]),
    .st_wdata_i  (cpu_wdata),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (off_q),
    .ld_word_i   (data_q),
    .ld_data_o   (ld_data)
  );

  // Next-state and capture logic for the access FSM.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_req_d   = mem_req_q;
    data_d      = data_q;
    fault_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          we_d        = cpu_we;
          funct3_d    = cpu_funct3;
          off_d       = cpu_addr[1:0];
          mem_addr_d  = cpu_addr[ADDR_W+1:2];
          mem_wdata_d = st_wdata;
          mem_be_d    = st_be;
          data_d      = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (is_misaligned(f3_size(cpu_funct3), cpu_addr[1:0])) begin
            state_d = StDone;
            fault_d = 1'b1;
          end else begin
            state_d   = StReq;
            mem_req_d = 1'b1;
          end
`else
          state_d   = StReq;
          mem_req_d = 1'b1;
`endif
        end
      end
      StReq: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!we_q) data_d = mem_rdata;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_req_q   <= 1'b0;
      data_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_req_q   <= mem_req_d;
      data_q      <= data_d;
      fault_q     <= fault_d;
    end
  end

  // Core-facing outputs; load data only presented in DONE for a good load.
  always_comb begin
    cpu_stall = cpu_req & (state_q != StDone);
    cpu_rdata = (state_q == StDone && !we_q && !fault_q) ? ld_data : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    cpu_fault = fault_q;
`else
    cpu_fault = 1'b0;
`endif
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a simple ack-delay memory responder.
module tb_dmem_bridge;

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_stall, cpu_fault;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent access
  int          obs_stall, obs_req;
  logic        obs_stable, obs_fault, obs_fault_after, obs_req_done, obs_we;
  logic [31:0] obs_rdata, obs_wdata;
  logic [9:0]  obs_addr;
  logic [3:0]  obs_be;

  int   pulse_cnt = 0;
  logic prev_req  = 1'b0;

  dmem_bridge #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_fault  (cpu_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count mem_req rising edges, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_req && !prev_req) pulse_cnt <= pulse_cnt + 1;
    prev_req <= mem_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access from an IDLE sample point; returns at the IDLE after DONE.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int delay,
                            input logic [31:0] rword, input logic hold);
    logic done;
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wdata;
    mem_rdata = rword; mem_ack = 1'b0;
    #1;
    obs_stall = 0; obs_req = 0; obs_stable = 1'b1; done = 1'b0;
    obs_rdata = '0; obs_fault = 1'b0; obs_req_done = 1'b0;
    obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!cpu_stall) begin
        obs_rdata    = cpu_rdata;
        obs_fault    = cpu_fault;
        obs_req_done = mem_req;
        done         = 1'b1;
      end else begin
        obs_stall++;
        if (mem_req) begin
          obs_req++;
          if (obs_req == 1) begin
            obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
          end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                       mem_wdata !== obs_wdata || mem_we !== obs_we) begin
            obs_stable = 1'b0;
          end
        end
        mem_ack = mem_req && (obs_req > delay);
        @(negedge clk); #1;
      end
    end
    if (!done) check_eq("access_timeout", 32'd0, 32'd1);
    mem_ack = 1'b0;
    cpu_req = hold;
    @(negedge clk); #1;
    obs_fault_after = cpu_fault;
  endtask

  int p0;

  initial begin
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'b010;
    cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_stall", {31'd0, cpu_stall}, 32'd1);
    check_eq("rst_outs", {cpu_rdata | mem_wdata}, 32'd0);
    check_eq("rst_misc", {16'd0, mem_addr, mem_be, mem_we, cpu_fault}, 32'd0);
    rst = 1'b1;

    // SW, same-cycle ack
    run_access(1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    check_eq("sw_addr", {22'd0, obs_addr}, 32'd4);
    check_eq("sw_be", {28'd0, obs_be}, 32'hF);
    check_eq("sw_wdata", obs_wdata, 32'hDEADBEEF);
    check_eq("sw_we", {31'd0, obs_we}, 32'd1);
    check_eq("sw_stall", obs_stall, 32'd2);
    check_eq("sw_rdata", obs_rdata, 32'd0);
    check_eq("sw_req_done", {31'd0, obs_req_done}, 32'd0);

    // SB to lane 3, then LB / LBU back
    run_access(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0, 32'h0, 1'b0);
    check_eq("sb_be", {28'd0, obs_be}, 32'h8);
    check_eq("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    check_eq("sb_addr", {22'd0, obs_addr}, 32'd4);
    run_access(1'b0, 3'b000, 32'h13, 32'h0, 0, 32'hA500_0000, 1'b0);
    check_eq("lb_rdata", obs_rdata, 32'hFFFFFFA5);
    check_eq("lb_we", {31'd0, obs_we}, 32'd0);
    run_access(1'b0, 3'b100, 32'h13, 32'h0, 0, 32'hA500_0000, 1'b0);
    check_eq("lbu_rdata", obs_rdata, 32'h000000A5);

    // LH upper half, ack after 3 wait cycles
    run_access(1'b0, 3'b001, 32'h22, 32'h0, 3, 32'h80017FFF, 1'b0);
    check_eq("lh_req_cycles", obs_req, 32'd4);
    check_eq("lh_stable", {31'd0, obs_stable}, 32'd1);
    check_eq("lh_stall", obs_stall, 32'd5);
    check_eq("lh_rdata", obs_rdata, 32'hFFFF8001);
    check_eq("lh_addr", {22'd0, obs_addr}, 32'd8);
    run_access(1'b0, 3'b101, 32'h20, 32'h0, 1, 32'h80017FFF, 1'b0);
    check_eq("lhu_rdata", obs_rdata, 32'h00007FFF);

    // SH upper half lanes
    run_access(1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 2, 32'h0, 1'b0);
    check_eq("sh_be", {28'd0, obs_be}, 32'hC);
    check_eq("sh_wdata", obs_wdata, 32'hBEEFBEEF);
    check_eq("sh_stable", {31'd0, obs_stable}, 32'd1);

    // Undefined funct3 behaves as word; high address bits alias
    run_access(1'b0, 3'b011, 32'h0000_1008, 32'h0, 0, 32'hCAFEF00D, 1'b0);
    check_eq("f3_011_rdata", obs_rdata, 32'hCAFEF00D);
    check_eq("alias_addr", {22'd0, obs_addr}, 32'd2);

    // Back-to-back LW with cpu_req held
    p0 = pulse_cnt;
    run_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h12345678, 1'b1);
    check_eq("b2b0_rdata", obs_rdata, 32'h12345678);
    check_eq("b2b0_stall", obs_stall, 32'd2);
    run_access(1'b0, 3'b010, 32'h44, 32'h0, 0, 32'h9ABCDEF0, 1'b0);
    check_eq("b2b1_rdata", obs_rdata, 32'h9ABCDEF0);
    check_eq("b2b1_stall", obs_stall, 32'd2);
    check_eq("b2b1_addr", {22'd0, obs_addr}, 32'h11);
    check_eq("b2b_pulses", pulse_cnt - p0, 32'd2);

    // Misaligned LW
    run_access(1'b0, 3'b010, 32'h2, 32'h0, 0, 32'h11223344, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("mis_req", obs_req, 32'd0);
    check_eq("mis_fault", {31'd0, obs_fault}, 32'd1);
    check_eq("mis_rdata", obs_rdata, 32'd0);
    check_eq("mis_stall", obs_stall, 32'd1);
`else
    check_eq("mis_req", obs_req, 32'd1);
    check_eq("mis_fault", {31'd0, obs_fault}, 32'd0);
    check_eq("mis_rdata", obs_rdata, 32'h11223344);
    check_eq("mis_addr", {22'd0, obs_addr}, 32'd0);
`endif
    check_eq("mis_fault_after", {31'd0, obs_fault_after}, 32'd0);

    // Reset while in REQ: mem_req drops without a clock edge
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h80; mem_ack = 1'b0;
    @(negedge clk); #1;
    check_eq("midrst_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_req_after", {31'd0, mem_req}, 32'd0);
    check_eq("midrst_stall", {31'd0, cpu_stall}, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Recovery access after reset
    run_access(1'b0, 3'b100, 32'h81, 32'h0, 1, 32'h0000_C300, 1'b0);
    check_eq("post_rst_lbu", obs_rdata, 32'h000000C3);
    check_eq("post_rst_addr", {22'd0, obs_addr}, 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
